// File: rtl/difftest_step_pkg.sv
// Shared types, default parameter values and helpers for the difftest step controller.
package difftest_step_pkg;

    typedef enum logic [2:0] {
        INIT,
        ACCUM,
        REQ,
        WAIT,
        DONE
    } step_state_t;

    localparam int unsigned DEF_NUM_CORES       = 1;
    localparam int unsigned DEF_STEP_WIDTH      = 8;
    localparam int unsigned DEF_ACC_WIDTH       = 16;
    localparam int unsigned DEF_BATCH_THRESHOLD = 1;
    localparam int unsigned DEF_CYCLE_WIDTH     = 64;

    // Largest accumulator value that still leaves room for one maximum step.
    // Shifting by 64 yields 0, so the modular subtraction stays correct at full width.
    function automatic logic [63:0] headroom_limit(input int unsigned acc_w, input int unsigned step_w);
        logic [63:0] one;
        one = 64'd1;
        return (one << acc_w) - (one << step_w);
    endfunction

endpackage

// File: rtl/difftest_step_acc.sv
// Per-core saturating batch accumulator with threshold, headroom and overflow status.
module difftest_step_acc
    import difftest_step_pkg::*;
#(
    parameter int unsigned STEP_WIDTH      = DEF_STEP_WIDTH,
    parameter int unsigned ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int unsigned BATCH_THRESHOLD = DEF_BATCH_THRESHOLD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  thresh,
    output logic                  low_headroom,
    output logic                  overflow
);

    localparam logic [ACC_WIDTH-1:0] LIMIT     = ACC_WIDTH'(headroom_limit(ACC_WIDTH, STEP_WIDTH));
    localparam logic [ACC_WIDTH-1:0] THRESHOLD = ACC_WIDTH'(BATCH_THRESHOLD);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   raw;

    // sum is the saturated acc + step; it feeds both the update and the batch snapshot
    always_comb begin
        raw          = {1'b0, acc} + {1'b0, ACC_WIDTH'(step)};
        sum          = raw[ACC_WIDTH] ? '1 : raw[ACC_WIDTH-1:0];
        thresh       = (sum >= THRESHOLD);
        low_headroom = (acc > LIMIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (enable) begin
            acc <= clear ? '0 : sum;
            if (raw[ACC_WIDTH]) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/difftest_step_ctrl.sv
// Multi-core difftest step controller: batches commit counts, hands them to the
// checker over valid/ready, waits for the verdict and owns cycle count/watchdog.
module difftest_step_ctrl
    import difftest_step_pkg::*;
#(
    parameter int unsigned NUM_CORES       = DEF_NUM_CORES,
    parameter int unsigned STEP_WIDTH      = DEF_STEP_WIDTH,
    parameter int unsigned ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int unsigned BATCH_THRESHOLD = DEF_BATCH_THRESHOLD,
    parameter int unsigned CYCLE_WIDTH     = DEF_CYCLE_WIDTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CORES*STEP_WIDTH-1:0] core_step,
    input  logic [CYCLE_WIDTH-1:0]          max_cycles,
    output logic                            req_valid,
    input  logic                            req_ready,
    output logic [NUM_CORES*ACC_WIDTH-1:0]  req_step,
    output logic [CYCLE_WIDTH-1:0]          req_cycle,
    input  logic                            rsp_valid,
    input  logic                            rsp_fail,
    output logic                            stall,
    output logic                            init_pulse,
    output logic [CYCLE_WIDTH-1:0]          n_cycles,
    output logic                            done,
    output logic                            fail,
    output logic                            timeout,
    output logic                            overflow
);

    step_state_t                      state;
    logic [NUM_CORES*STEP_WIDTH-1:0]  step_d;
    logic [NUM_CORES*ACC_WIDTH-1:0]   sum_all;
    logic [NUM_CORES-1:0]             thresh;
    logic [NUM_CORES-1:0]             low_hr;
    logic [NUM_CORES-1:0]             ovf;

    logic active;
    logic any_thresh;
    logic wd_fire;
    logic rsp_ok;
    logic rsp_bad;
    logic go_done;
    logic snapshot;
    logic acc_en;

    // Entering DONE freezes both the accumulators and n_cycles on that same edge,
    // so the watchdog reports at exactly n_cycles == max_cycles.
    always_comb begin
        active     = (state == ACCUM) || (state == REQ) || (state == WAIT);
        any_thresh = |thresh;
        wd_fire    = (max_cycles != '0) && (n_cycles >= max_cycles);
        rsp_ok     = (state == WAIT) && rsp_valid && !rsp_fail;
        rsp_bad    = (state == WAIT) && rsp_valid && rsp_fail;
        go_done    = active && (wd_fire || rsp_bad);
        snapshot   = !go_done && any_thresh && ((state == ACCUM) || rsp_ok);
        acc_en     = active && !go_done;
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        difftest_step_acc #(
            .STEP_WIDTH      (STEP_WIDTH),
            .ACC_WIDTH       (ACC_WIDTH),
            .BATCH_THRESHOLD (BATCH_THRESHOLD)
        ) u_acc (
            .clock        (clock),
            .reset        (reset),
            .enable       (acc_en),
            .clear        (snapshot),
            .step         (step_d[i*STEP_WIDTH +: STEP_WIDTH]),
            .sum          (sum_all[i*ACC_WIDTH +: ACC_WIDTH]),
            .thresh       (thresh[i]),
            .low_headroom (low_hr[i]),
            .overflow     (ovf[i])
        );
    end

    assign overflow   = |ovf;
    assign stall      = done || (((state == REQ) || (state == WAIT)) && (|low_hr));
    // INIT is the reset state, so the pulse is qualified by reset being released.
    assign init_pulse = (state == INIT) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INIT;
            step_d    <= '0;
            n_cycles  <= '0;
            req_valid <= 1'b0;
            req_step  <= '0;
            req_cycle <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            step_d <= core_step;
            if (state != DONE && !go_done) begin
                n_cycles <= n_cycles + CYCLE_WIDTH'(1);
            end
            if (snapshot) begin
                req_step  <= sum_all;
                req_cycle <= n_cycles;
            end
            if (go_done) begin
                state     <= DONE;
                req_valid <= 1'b0;
                done      <= 1'b1;
                fail      <= rsp_bad;
                timeout   <= !rsp_bad;
            end else begin
                case (state)
                    INIT: state <= ACCUM;
                    ACCUM: begin
                        if (snapshot) begin
                            state     <= REQ;
                            req_valid <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (req_ready) begin
                            state     <= WAIT;
                            req_valid <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (snapshot) begin
                            state     <= REQ;
                            req_valid <= 1'b1;
                        end else if (rsp_ok) begin
                            state <= ACCUM;
                        end
                    end
                    default: state <= DONE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_difftest_step_ctrl.sv
// Directed bench for difftest_step_ctrl across three parameter sets.
module tb_difftest_step_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    // Instance A: defaults (1 core, threshold 1)
    logic [7:0]  a_step = '0;
    logic [63:0] a_max = '0;
    logic        a_ready = 1'b0, a_rsp_valid = 1'b0, a_rsp_fail = 1'b0;
    logic        a_req_valid, a_stall, a_init, a_done, a_fail, a_timeout, a_ovf;
    logic [15:0] a_req_step;
    logic [63:0] a_req_cycle, a_ncyc;

    // Instance B: 2 cores, threshold 16
    logic [15:0] b_step = '0;
    logic [63:0] b_max = '0;
    logic        b_ready = 1'b0, b_rsp_valid = 1'b0, b_rsp_fail = 1'b0;
    logic        b_req_valid, b_stall, b_init, b_done, b_fail, b_timeout, b_ovf;
    logic [31:0] b_req_step;
    logic [63:0] b_req_cycle, b_ncyc;

    // Instance C: 10-bit accumulator
    logic [7:0]  c_step = '0;
    logic [63:0] c_max = '0;
    logic        c_ready = 1'b0, c_rsp_valid = 1'b0, c_rsp_fail = 1'b0;
    logic        c_req_valid, c_stall, c_init, c_done, c_fail, c_timeout, c_ovf;
    logic [9:0]  c_req_step;
    logic [63:0] c_req_cycle, c_ncyc;

    difftest_step_ctrl #(
        .NUM_CORES(1), .STEP_WIDTH(8), .ACC_WIDTH(16), .BATCH_THRESHOLD(1), .CYCLE_WIDTH(64)
    ) u_a (
        .clock(clock), .reset(reset), .core_step(a_step), .max_cycles(a_max),
        .req_valid(a_req_valid), .req_ready(a_ready), .req_step(a_req_step),
        .req_cycle(a_req_cycle), .rsp_valid(a_rsp_valid), .rsp_fail(a_rsp_fail),
        .stall(a_stall), .init_pulse(a_init), .n_cycles(a_ncyc), .done(a_done),
        .fail(a_fail), .timeout(a_timeout), .overflow(a_ovf)
    );

    difftest_step_ctrl #(
        .NUM_CORES(2), .STEP_WIDTH(8), .ACC_WIDTH(16), .BATCH_THRESHOLD(16), .CYCLE_WIDTH(64)
    ) u_b (
        .clock(clock), .reset(reset), .core_step(b_step), .max_cycles(b_max),
        .req_valid(b_req_valid), .req_ready(b_ready), .req_step(b_req_step),
        .req_cycle(b_req_cycle), .rsp_valid(b_rsp_valid), .rsp_fail(b_rsp_fail),
        .stall(b_stall), .init_pulse(b_init), .n_cycles(b_ncyc), .done(b_done),
        .fail(b_fail), .timeout(b_timeout), .overflow(b_ovf)
    );

    difftest_step_ctrl #(
        .NUM_CORES(1), .STEP_WIDTH(8), .ACC_WIDTH(10), .BATCH_THRESHOLD(1), .CYCLE_WIDTH(64)
    ) u_c (
        .clock(clock), .reset(reset), .core_step(c_step), .max_cycles(c_max),
        .req_valid(c_req_valid), .req_ready(c_ready), .req_step(c_req_step),
        .req_cycle(c_req_cycle), .rsp_valid(c_rsp_valid), .rsp_fail(c_rsp_fail),
        .stall(c_stall), .init_pulse(c_init), .n_cycles(c_ncyc), .done(c_done),
        .fail(c_fail), .timeout(c_timeout), .overflow(c_ovf)
    );

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench in the INIT cycle (n_cycles = 0) of every instance.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        check({tag, "_rst_req_valid"}, a_req_valid, 0);
        check({tag, "_rst_req_step"},  a_req_step, 0);
        check({tag, "_rst_req_cycle"}, a_req_cycle, 0);
        check({tag, "_rst_stall"},     a_stall, 0);
        check({tag, "_rst_init"},      a_init, 0);
        check({tag, "_rst_ncyc"},      a_ncyc, 0);
        check({tag, "_rst_flags"},     {a_done, a_fail, a_timeout, a_ovf}, 0);
        reset = 1'b0;
        #1;
        check({tag, "_init_pulse"}, a_init, 1);
        check({tag, "_init_ncyc"},  a_ncyc, 0);
    endtask

    initial begin
        // Single core, per-cycle checking: step=3 in cycle 5 -> req_valid in cycle 7
        do_reset("t1");
        tick();
        check("t1_init_low", a_init, 0);
        repeat (4) tick();
        check("t1_ncyc5", a_ncyc, 5);
        a_step = 8'd3;
        a_ready = 1'b1;
        tick();
        a_step = '0;
        check("t1_rv_c6", a_req_valid, 0);
        tick();
        check("t1_rv_c7", a_req_valid, 1);
        check("t1_step_c7", a_req_step, 3);
        check("t1_cycle_c7", a_req_cycle, 6);
        tick();
        check("t1_rv_wait", a_req_valid, 0);
        a_rsp_valid = 1'b1;
        tick();
        a_rsp_valid = 1'b0;
        check("t1_rv_accum", a_req_valid, 0);
        check("t1_done_accum", a_done, 0);
        a_step = 8'd1;
        tick();
        a_step = '0;
        tick();
        check("t1_rv_second", a_req_valid, 1);
        check("t1_step_second", a_req_step, 1);
        check("t1_cycle_second", a_req_cycle, 10);
        a_ready = 1'b0;

        // Two cores, threshold 16, continuous {core1=1, core0=4}
        do_reset("t2");
        tick();
        b_step = {8'd1, 8'd4};
        repeat (4) tick();
        check("t2_rv_c5", b_req_valid, 0);
        tick();
        check("t2_rv_c6", b_req_valid, 1);
        check("t2_step_b1", b_req_step, 32'h0004_0010);
        check("t2_cycle_b1", b_req_cycle, 5);
        tick();
        check("t2_rv_hold", b_req_valid, 1);
        check("t2_step_hold", b_req_step, 32'h0004_0010);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check("t2_rv_wait", b_req_valid, 0);
        b_rsp_valid = 1'b1;
        tick();
        b_rsp_valid = 1'b0;
        check("t2_rv_accum", b_req_valid, 0);
        tick();
        check("t2_rv_b2", b_req_valid, 1);
        check("t2_step_b2", b_req_step, 32'h0004_0010);
        check("t2_cycle_b2", b_req_cycle, 9);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        tick();
        tick();
        check("t2_rv_wait2", b_req_valid, 0);
        b_rsp_valid = 1'b1;
        tick();
        b_rsp_valid = 1'b0;
        check("t2_rv_b2b", b_req_valid, 1);
        check("t2_step_b3", b_req_step, 32'h0004_0010);
        check("t2_cycle_b3", b_req_cycle, 13);
        check("t2_stall", b_stall, 0);
        b_step = '0;

        // 10-bit accumulator, req_ready low, step=255 every cycle
        do_reset("t3");
        tick();
        c_step = 8'd255;
        tick();
        tick();
        check("t3_rv", c_req_valid, 1);
        check("t3_step_first", c_req_step, 255);
        check("t3_stall_n3", c_stall, 0);
        repeat (3) tick();
        check("t3_stall_765", c_stall, 0);
        check("t3_ovf_765", c_ovf, 0);
        tick();
        check("t3_stall_1020", c_stall, 1);
        check("t3_ovf_1020", c_ovf, 0);
        tick();
        check("t3_ovf_sat", c_ovf, 1);
        check("t3_stall_sat", c_stall, 1);
        check("t3_step_stable", c_req_step, 255);
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        check("t3_stall_wait", c_stall, 1);
        c_rsp_valid = 1'b1;
        tick();
        c_rsp_valid = 1'b0;
        check("t3_rv_sat", c_req_valid, 1);
        check("t3_step_sat", c_req_step, 1023);
        check("t3_stall_cleared", c_stall, 0);
        c_step = '0;

        // Watchdog at 50 cycles with no steps
        a_max = 64'd50;
        do_reset("t4");
        repeat (50) tick();
        check("t4_ncyc50", a_ncyc, 50);
        check("t4_done_pre", a_done, 0);
        tick();
        check("t4_timeout", a_timeout, 1);
        check("t4_done", a_done, 1);
        check("t4_fail", a_fail, 0);
        check("t4_stall", a_stall, 1);
        check("t4_rv", a_req_valid, 0);
        check("t4_ncyc_at_done", a_ncyc, 50);
        repeat (3) tick();
        check("t4_ncyc_frozen", a_ncyc, 50);
        check("t4_done_sticky", a_done, 1);

        // rsp_fail in the same cycle the watchdog fires
        a_max = 64'd10;
        do_reset("t5");
        tick();
        a_step = 8'd1;
        a_ready = 1'b1;
        tick();
        a_step = '0;
        tick();
        tick();
        a_ready = 1'b0;
        check("t5_rv_wait", a_req_valid, 0);
        repeat (6) tick();
        check("t5_ncyc10", a_ncyc, 10);
        check("t5_done_pre", a_done, 0);
        a_rsp_valid = 1'b1;
        a_rsp_fail = 1'b1;
        tick();
        a_rsp_valid = 1'b0;
        a_rsp_fail = 1'b0;
        check("t5_fail", a_fail, 1);
        check("t5_timeout", a_timeout, 0);
        check("t5_done", a_done, 1);
        check("t5_ncyc", a_ncyc, 10);

        // Reset asserted while a batch is outstanding in WAIT
        a_max = '0;
        do_reset("t6a");
        tick();
        a_step = 8'd2;
        a_ready = 1'b1;
        tick();
        a_step = 8'd5;
        tick();
        tick();
        a_ready = 1'b0;
        check("t6_rv_wait", a_req_valid, 0);
        check("t6_step_wait", a_req_step, 2);
        check("t6_stall_wait", a_stall, 0);
        do_reset("t6b");
        a_step = '0;
        tick();
        check("t6_init_once", a_init, 0);
        check("t6_ncyc1", a_ncyc, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/difftest_step_ctrl.md
# difftest_step_ctrl

Synthesizable multi-core difftest step controller. It sits between the DUT commit counters and the host-side checker (DPI or gateway FIFO). It registers per-core commit counts, accumulates them into batches, and issues each batch to the checker over a valid/ready handshake. It also waits for the check result, stalls the DUT when accumulator headroom runs out, and owns the cycle counter, the one-shot init pulse and the max-cycle watchdog.

## Interface
- NUM_CORES, 1: number of cores/step channels
- STEP_WIDTH, 8: width of one core's per-cycle commit count
- ACC_WIDTH, 16: per-core batch accumulator width; must be > STEP_WIDTH
- BATCH_THRESHOLD, 1: issue a batch when any core's accumulated count is >= this; 1 gives per-cycle checking
- CYCLE_WIDTH, 64: cycle counter and max-cycle width

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- core_step  in  NUM_CORES*STEP_WIDTH  per-core commits this cycle; core i is at [i*STEP_WIDTH +: STEP_WIDTH]
- max_cycles  in  CYCLE_WIDTH  watchdog limit; 0 = unlimited
- req_valid  out  1  batch available to checker
- req_ready  in  1  checker accepts batch
- req_step  out  NUM_CORES*ACC_WIDTH  per-core step counts of the batch
- req_cycle  out  CYCLE_WIDTH  n_cycles value at batch snapshot
- rsp_valid  in  1  checker result strobe
- rsp_fail  in  1  result: 1 = mismatch
- stall  out  1  DUT hold request
- init_pulse  out  1  one cycle, first cycle after reset release
- n_cycles  out  CYCLE_WIDTH  cycles since reset release
- done / fail / timeout / overflow  out  1 each  sticky status

## Operation
- Input stage:
  - core_step is registered into step_d every cycle (reset 0).
  - Only step_d feeds the accumulators.
- FSM states: INIT, ACCUM, REQ, WAIT, DONE. Reset enters INIT.
- INIT: lasts exactly one cycle.
  - init_pulse = 1.
  - Next state is ACCUM.
- ACCUM:
  - acc[i] += step_d[i].
  - If any (acc[i] + step_d[i]) >= BATCH_THRESHOLD: snapshot req_step[i] = acc[i] + step_d[i] and req_cycle = n_cycles, clear all acc to 0, and go to REQ.
- REQ:
  - req_valid = 1.
  - req_step and req_cycle are held stable.
  - On req_valid && req_ready at a clock edge, go to WAIT.
- WAIT:
  - rsp_valid && rsp_fail: go to DONE, fail = 1.
  - rsp_valid && !rsp_fail: if any acc[i] + step_d[i] >= BATCH_THRESHOLD, snapshot and go to REQ directly; otherwise go to ACCUM.
  - rsp_valid is ignored in every state other than WAIT.
- Accumulation in REQ and WAIT: acc keeps accumulating step_d.
- stall = 1 in DONE, and in REQ/WAIT whenever any acc[i] > 2^ACC_WIDTH − 2^STEP_WIDTH (less than one maximum step of headroom).
- Accumulator saturation:
  - An add that would exceed 2^ACC_WIDTH − 1 saturates at all-ones and sets overflow.
  - The snapshot path saturates identically.
- Watchdog:
  - In ACCUM/REQ/WAIT, if max_cycles != 0 and n_cycles >= max_cycles: go to DONE, timeout = 1.
  - If rsp_fail arrives in the same cycle, fail wins: fail = 1, timeout stays 0.
- DONE: terminal until reset.
  - done = 1, stall = 1, req_valid = 0.
  - n_cycles and the accumulators are frozen.
- n_cycles: +1 every cycle out of reset except in DONE; wraps modulo 2^CYCLE_WIDTH.

## Timing
- Reset values: req_valid, stall, init_pulse, done, fail, timeout and overflow are 0. req_step, req_cycle, n_cycles, acc and step_d are 0.
- init_pulse is high in the first cycle with reset low, with n_cycles = 0.
- Latency: core_step presented in cycle c, ACCUM, threshold met → req_valid high in cycle c+2.
- The checker must not assert rsp_valid in the same cycle as the request transfer; the earliest response is the first WAIT cycle.
- Back-to-back batches: with rsp_valid in WAIT and the threshold already met, req_valid is high again in the next cycle (zero idle cycles).
- Status flags are registered and rise the cycle after the triggering event.
- Reset asserted in any state, including REQ/WAIT, drops the outstanding batch and restores all reset values at the next edge.

## Structure
- Package difftest_step_pkg holds:
  - the state enum (INIT, ACCUM, REQ, WAIT, DONE);
  - the default parameter constants;
  - the headroom-limit function of ACC_WIDTH and STEP_WIDTH.
- Sub-module difftest_step_acc: one per core, generated NUM_CORES times.
  - Contains the saturating accumulator, the threshold compare, the headroom compare and the overflow flag.
  - Takes clear and enable inputs from the top FSM.

## Test plan
- NUM_CORES=1, BATCH_THRESHOLD=1:
  - Stimulus: step=3 in cycle 5, req_ready=1; response rsp_valid/!fail in the first WAIT cycle.
  - Required: req_valid in cycle 7 with req_step=3, then ACCUM.
- NUM_CORES=2, BATCH_THRESHOLD=16:
  - Stimulus: core0 steps 4/cycle, core1 steps 1/cycle.
  - Required: batch {core0=16, core1=4} after the 4th accumulated cycle; steps arriving during REQ/WAIT appear in the next batch with no loss.
- ACC_WIDTH=10, STEP_WIDTH=8, req_ready=0:
  - Stimulus: step=255 each cycle.
  - Required: stall rises once acc > 768; continued steps saturate acc at 1023 and set overflow.
- max_cycles=50, no steps:
  - Required: timeout=1 and done=1 at n_cycles=50; n_cycles frozen; stall=1.
- rsp_fail=1 in the same cycle the watchdog fires:
  - Required: fail=1, timeout=0, done=1.
- Reset asserted during WAIT:
  - Required: next cycle all outputs at reset values; init_pulse fires again on release.
